// File: rtl/sign_truncate_pkg.sv
// Shared types and constants for the store-path narrowing unit.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sign_truncate_pkg;

    // Store width as encoded on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Sequencer states: sub-word stores walk RD -> MRG -> WR.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // True when the request cannot be performed: illegal size or a
    // half/word that does not sit on its natural boundary.
    function automatic logic req_is_bad(input size_e sz, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sign_truncate_store_byte_lane_merge.sv
// Replaces the addressed byte/half lane of an old memory word with store data.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module byte_lane_merge
    import sign_truncate_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] data,
    input  size_e             size,
    input  logic [1:0]        addr_lo,
    output logic [WORD_W-1:0] merged
);

    // Little-endian lane select: byte lane addr_lo*8, half lane addr_lo[1]*16.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = data[BYTE_W-1:0];
                    2'd1:    merged[15:8]  = data[BYTE_W-1:0];
                    2'd2:    merged[23:16] = data[BYTE_W-1:0];
                    default: merged[31:24] = data[BYTE_W-1:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merged[31:16] = data[HALF_W-1:0];
                end else begin
                    merged[15:0]  = data[HALF_W-1:0];
                end
            end
            default: merged = data;
        endcase
    end

endmodule

// File: rtl/sign_truncate_store.sv
// Store narrowing unit: writes byte/half/word of a register into word memory, RMW for sub-words.
// Latency: word store done in cycle 1, byte/half in cycle 3, error in cycle 1 after accept.
// Backpressure: req_ready low from accept until back in IDLE; optional ovf check via SIGN_TRUNC_OVF_CHECK_EN.
module sign_truncate_store
    import sign_truncate_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              err,
    output logic              ovf
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    size_e               size_q,  size_d;
    logic                ovf_q,   ovf_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    size_e               req_sz;
    logic                accept;
    logic                ovf_chk;
    logic [DATA_W-1:0]   merged;

    assign req_sz = size_e'(req_size);
    assign accept = req_valid && req_ready;

`ifdef SIGN_TRUNC_OVF_CHECK_EN
    // Flag values that the load-side sign extender would not reproduce.
    always_comb begin
        ovf_chk = 1'b0;
        case (req_sz)
            SZ_BYTE: ovf_chk = (req_data !=
                {{(DATA_W-BYTE_W){req_data[BYTE_W-1]}}, req_data[BYTE_W-1:0]});
            SZ_HALF: ovf_chk = (req_data !=
                {{(DATA_W-HALF_W){req_data[HALF_W-1]}}, req_data[HALF_W-1:0]});
            default: ovf_chk = 1'b0;
        endcase
    end
`else
    assign ovf_chk = 1'b0;
`endif

    byte_lane_merge u_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .merged   (merged)
    );

    // Next-state and request capture; the merge result is only taken in MRG.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        ovf_d   = ovf_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    size_d = req_sz;
                    if (req_is_bad(req_sz, req_addr[1:0])) begin
                        state_d = ERR;
                        ovf_d   = 1'b0;
                    end else if (req_sz == SZ_WORD) begin
                        state_d = WR;
                        wdata_d = req_data;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = RD;
                        ovf_d   = ovf_chk;
                    end
                end
            end
            RD:      state_d = MRG;
            MRG: begin
                wdata_d = merged;
                state_d = WR;
            end
            WR:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SZ_BYTE;
            ovf_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            ovf_q   <= ovf_d;
            wdata_q <= wdata_d;
        end
    end

    // Strobes and status decode directly from the registered state.
    assign req_ready = (state_q == IDLE);
    assign mem_rd_en = (state_q == RD);
    assign mem_wr_en = (state_q == WR);
    assign done      = (state_q == WR) || (state_q == ERR);
    assign err       = (state_q == ERR);
    assign ovf       = (state_q == WR) && ovf_q;
    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_wdata = wdata_q;

endmodule
